// File: rtl/servo_pkg.sv
// Shared widths and pulse-width arithmetic for the servo PWM path.
// Everything is unsigned microseconds, US_W bits wide.
package servo_pkg;

  localparam int US_W = 11;

  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] val,
                                               input logic [US_W-1:0] lo,
                                               input logic [US_W-1:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  // The difference is taken one bit wider so that cur-tgt can never wrap.
  function automatic logic [US_W-1:0] slew_us(input logic [US_W-1:0] cur,
                                              input logic [US_W-1:0] tgt,
                                              input logic [US_W-1:0] step);
    logic [US_W:0] diff;
    if (step == '0) return tgt;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      return (diff > {1'b0, step}) ? cur + step : tgt;
    end
    diff = {1'b0, cur} - {1'b0, tgt};
    return (diff > {1'b0, step}) ? cur - step : tgt;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: tick_us is high for one clk cycle every DIV cycles.
// Also used by the sensor debounce logic.
module us_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick_us
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] prescaler;

  assign tick_us = (prescaler == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prescaler <= '0;
    else if (tick_us) prescaler <= '0;
    else              prescaler <= prescaler + PW'(1);
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz servo/ESC PWM generator: the command is clamped, slew-limited and
// latched only at frame boundaries, so a pulse in progress is never cut short.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int NEUTRAL_US  = 1500,
  parameter int MAX_STEP_US = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [US_W-1:0] x_val_checked,
  output logic            pwm_out,
  output logic            frame_start,
  output logic [US_W-1:0] pulse_us_active
);

  localparam int DIV = us_div(CLK_FREQ_HZ);
  localparam int CW  = $clog2(FRAME_US);

  localparam logic [US_W-1:0] MIN_V  = US_W'(MIN_US);
  localparam logic [US_W-1:0] MAX_V  = US_W'(MAX_US);
  localparam logic [US_W-1:0] NEU_V  = US_W'(NEUTRAL_US);
  localparam logic [US_W-1:0] STEP_V = US_W'(MAX_STEP_US);

  if (!(MIN_US <= NEUTRAL_US && NEUTRAL_US <= MAX_US &&
        MAX_US < FRAME_US && MAX_US < 2048)) begin : g_bad_width
    $error("servo_pwm_gen: illegal pulse-width parameters");
  end
  if (CLK_FREQ_HZ % 1_000_000 != 0 || DIV < 1) begin : g_bad_clk
    $error("servo_pwm_gen: CLK_FREQ_HZ must be a multiple of 1 MHz");
  end

  logic            tick_us;
  logic            boundary;
  logic [CW-1:0]   us_cnt, us_cnt_next;
  logic            en_q, en_q_next;
  logic [US_W-1:0] pulse_next;
  logic [US_W-1:0] target;

  us_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .tick_us (tick_us)
  );

  assign boundary = tick_us && (us_cnt == CW'(FRAME_US - 1));
  assign target   = (x_val_checked == '0) ? NEU_V
                                          : clamp_us(x_val_checked, MIN_V, MAX_V);

  always_comb begin
    us_cnt_next = us_cnt;
    en_q_next   = en_q;
    pulse_next  = pulse_us_active;
    if (tick_us) us_cnt_next = boundary ? '0 : us_cnt + CW'(1);
    if (boundary) begin
      en_q_next  = en;
      pulse_next = slew_us(pulse_us_active, target, STEP_V);
    end
  end

  // pwm_out is computed from next-state values so it lines up with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt          <= '0;
      en_q            <= 1'b0;
      pulse_us_active <= NEU_V;
      pwm_out         <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      us_cnt          <= us_cnt_next;
      en_q            <= en_q_next;
      pulse_us_active <= pulse_next;
      pwm_out         <= en_q_next && (32'(us_cnt_next) < 32'(pulse_next));
      frame_start     <= boundary;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized check of servo_pwm_gen (slewed and unslewed instances) against
// a frame-level reference model, plus directed slew/clamp/enable/reset cases.
module tb_servo_pwm_gen;

  localparam int CLK_HZ = 2_000_000;
  localparam int DIV    = 2;
  localparam int FRAME  = 50;
  localparam int MIN    = 10;
  localparam int MAX    = 40;
  localparam int NEU    = 25;
  localparam int STEP   = 4;
  localparam int L      = FRAME * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [10:0] x   = 11'(NEU);

  logic        pwm_a, fs_a, pwm_b, fs_b;
  logic [10:0] act_a, act_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(.CLK_FREQ_HZ(CLK_HZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
                  .NEUTRAL_US(NEU), .MAX_STEP_US(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .x_val_checked(x),
    .pwm_out(pwm_a), .frame_start(fs_a), .pulse_us_active(act_a));

  servo_pwm_gen #(.CLK_FREQ_HZ(CLK_HZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
                  .NEUTRAL_US(NEU), .MAX_STEP_US(0)) dut_ns (
    .clk(clk), .rst(rst), .en(en), .x_val_checked(x),
    .pwm_out(pwm_b), .frame_start(fs_b), .pulse_us_active(act_b));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int target_of(input int v);
    if (v == 0)  return NEU;
    if (v < MIN) return MIN;
    if (v > MAX) return MAX;
    return v;
  endfunction

  function automatic int slew_to(input int cur, input int tgt, input int step);
    if (step == 0) return tgt;
    if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
    return (cur - tgt > step) ? cur - step : tgt;
  endfunction

  // Reference: t = clk edges since reset release; every L edges a new frame
  // latches en and the (clamped, slewed) command from the inputs of that edge.
  int t, w_a, w_b, tgt_m;
  bit en_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; w_a = NEU; w_b = NEU; en_m = 0;
    end else begin
      t++;
      if (t % L == 0) begin
        tgt_m = target_of(int'(x));
        en_m  = en;
        w_a   = slew_to(w_a, tgt_m, STEP);
        w_b   = tgt_m;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pwm_a", int'(pwm_a), int'(en_m && (t % L) < w_a * DIV));
      chk("pwm_b", int'(pwm_b), int'(en_m && (t % L) < w_b * DIV));
      chk("fs_a",  int'(fs_a),  int'(t > 0 && t % L == 0));
      chk("fs_b",  int'(fs_b),  int'(t > 0 && t % L == 0));
      chk("act_a", int'(act_a), w_a);
      chk("act_b", int'(act_b), w_b);
    end
  end

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_a && n < L + 5);
    if (!fs_a) chk("fs_timeout", 0, 1);
  endtask

  function automatic logic [10:0] pick_x();
    case ($urandom_range(0, 4))
      0:       return 11'd0;
      1:       return 11'($urandom_range(1, MIN - 1));
      4:       return 11'($urandom_range(MAX + 1, 2047));
      default: return 11'($urandom_range(MIN, MAX));
    endcase
  endfunction

  int slew_up[5]   = '{29, 33, 37, 40, 40};
  int slew_dn[6]   = '{36, 32, 28, 24, 23, 23};
  int cnt, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_act", int'(act_a), NEU);
    chk("rst_pwm", int'(pwm_a), 0);
    en = 1'b1;
    x  = 11'd40;
    #2 rst = 1'b0;

    // slew up from neutral, then down to 23 with a final partial step
    foreach (slew_up[i]) begin
      wait_fs();
      chk("slew_up_a", int'(act_a), slew_up[i]);
      chk("slew_up_b", int'(act_b), 40);
    end
    x = 11'd23;
    foreach (slew_dn[i]) begin
      wait_fs();
      chk("slew_dn_a", int'(act_a), slew_dn[i]);
    end

    // unslewed instance: clamp high, clamp low, zero -> neutral
    x = 11'd2047; wait_fs(); chk("clamp_hi_b", int'(act_b), MAX);
    x = 11'd5;    wait_fs(); chk("clamp_lo_b", int'(act_b), MIN);
    x = 11'd0;    wait_fs(); chk("zero_b",     int'(act_b), NEU);

    // steady frame length, then en dropped mid-pulse and restored mid-frame
    wait_fs();
    cnt = 0;
    for (int i = 0; i < L; i++) begin
      if (pwm_b) cnt++;
      @(negedge clk);
    end
    chk("high_b", cnt, NEU * DIV);
    cnt = 0;
    for (int i = 0; i < L; i++) begin
      if (pwm_b) cnt++;
      if (i == 10) en = 1'b0;
      @(negedge clk);
    end
    chk("en_drop_full", cnt, NEU * DIV);
    cnt = 0;
    for (int i = 0; i < L; i++) begin
      if (pwm_b) cnt++;
      if (i == 30) en = 1'b1;
      @(negedge clk);
    end
    chk("en_off_frame", cnt, 0);

    // mid-frame glitch on x is ignored
    x = 11'd12;
    wait_fs();
    repeat (5) @(negedge clk);
    x = 11'd38;
    repeat (20) @(negedge clk);
    x = 11'd12;
    wait_fs();
    chk("glitch_b", int'(act_b), 12);

    // asynchronous reset in the middle of a pulse
    x = 11'd30;
    n = 0;
    while (!pwm_a && n < 3 * L) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", int'(pwm_a), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_pwm_a", int'(pwm_a), 0);
    chk("arst_act_a", int'(act_a), NEU);
    chk("arst_pwm_b", int'(pwm_b), 0);
    chk("arst_act_b", int'(act_b), NEU);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_a && n < L + 5);
    chk("first_fs", n, L);

    // randomized commands and enables, changing at arbitrary points in a frame
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0)  x  = pick_x();
      if ($urandom_range(0, 149) == 0) en = ~en;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
